// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Types shared by the CPU datapath and the board front-end.
//   aluop_t        : ALU operation code (4 bits, taken from SW[3:0] at the board)
//   aluseq_state_t : operand sequencer state, also driven to the board LEDs
//   sw_to_operand  : sign-extends the 17-bit switch value to a 32-bit operand
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SW_W   = 18;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_NOR = 4'h5,
    ALU_SLL = 4'h6,
    ALU_SRL = 4'h7,
    ALU_SRA = 4'h8,
    ALU_SLT = 4'h9
  } aluop_t;

  typedef enum logic [1:0] {
    SEQ_LOAD_A,
    SEQ_LOAD_B,
    SEQ_LOAD_OP,
    SEQ_SHOW
  } aluseq_state_t;

  // SW[16] is the sign bit of the 17-bit operand typed on the switches.
  function automatic logic [DATA_W-1:0] sw_to_operand(input logic [16:0] sw);
    return {{15{sw[16]}}, sw};
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer_if
// Bus between the operand sequencer and the ALU.
//   porta, portb : operands (sequencer -> ALU)
//   aluop        : operation (sequencer -> ALU)
//   result       : ALU portout (ALU -> sequencer)
//   negative, overflow, zero : ALU flags (ALU -> sequencer)
// Modports: master = sequencer side, slave = ALU side.
// -----------------------------------------------------------------------------
interface alu_operand_sequencer_if;
  import cpu_types_pkg::*;

  logic [DATA_W-1:0] porta;
  logic [DATA_W-1:0] portb;
  aluop_t            aluop;
  logic [DATA_W-1:0] result;
  logic              negative;
  logic              overflow;
  logic              zero;

  modport master (
    output porta, portb, aluop,
    input  result, negative, overflow, zero
  );

  modport slave (
    input  porta, portb, aluop,
    output result, negative, overflow, zero
  );

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes one active-low push-button, debounces it and emits a single-cycle
// pulse when the debounced level falls (key pressed). Release gives no pulse.
//   CLK, RST : clock, asynchronous active-high reset
//   key_n    : raw button, active-low, asynchronous to CLK
//   press    : one-cycle pulse per accepted press (registered)
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          key_meta;
  logic          key_sync;
  logic          key_deb;
  logic          key_deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_meta  <= 1'b0;
      key_sync  <= 1'b0;
      key_deb   <= 1'b1;
      key_deb_d <= 1'b1;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      key_meta  <= key_n;
      key_sync  <= key_meta;
      key_deb_d <= key_deb;
      press     <= key_deb_d & ~key_deb;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (key_sync == key_deb) begin
        cnt <= '0;
      end else if (cnt == TC) begin
        key_deb <= key_sync;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
// Board front-end for the ALU: the operator enters operand A, operand B and the
// op code on the switches, confirming each with the enter key; the ALU result
// and flags are then captured for the hex display.
//   CLK, RST   : clock, asynchronous active-high reset
//   SW[17:0]   : raw switches; SW[16:0] is a signed operand, SW[3:0] the op code
//   KEY[3:0]   : raw buttons, active-low; KEY[0] enter, KEY[1] clear
//   alu        : operand/op outputs and result/flag inputs to the ALU
//   disp_val   : value shown on the hex digits
//   flags      : captured {negative, overflow, zero}
//   res_valid  : disp_val/flags hold a captured result
//   state_led  : current sequencer state
//
// state       | meaning
// SEQ_LOAD_A  | display switches, enter latches operand A
// SEQ_LOAD_B  | display switches, enter latches operand B
// SEQ_LOAD_OP | display SW[3:0], enter latches op code
// SEQ_SHOW    | capture result once, hold it; enter returns to SEQ_LOAD_A
// -----------------------------------------------------------------------------
module alu_operand_sequencer
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [SW_W-1:0]          SW,
  input  logic [3:0]               KEY,
  alu_operand_sequencer_if.master  alu,
  output logic [DATA_W-1:0]        disp_val,
  output logic [2:0]               flags,
  output logic                     res_valid,
  output logic [1:0]               state_led
);

  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic [DATA_W-1:0] sw_val;
  logic              enter_press;
  logic              clear_press;
  aluseq_state_t     state;
  logic [DATA_W-1:0] porta;
  logic [DATA_W-1:0] portb;
  aluop_t            aluop;
  logic              unused_ok;

  assign unused_ok = ^{KEY[3:2], sw_sync[17]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  assign sw_val = sw_to_operand(sw_sync[16:0]);

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
    .CLK   (CLK),
    .RST   (RST),
    .key_n (KEY[0]),
    .press (enter_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .CLK   (CLK),
    .RST   (RST),
    .key_n (KEY[1]),
    .press (clear_press)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= SEQ_LOAD_A;
      porta     <= '0;
      portb     <= '0;
      aluop     <= ALU_ADD;
      disp_val  <= '0;
      flags     <= '0;
      res_valid <= 1'b0;
    end else if (clear_press) begin
      // Clear has priority over a coincident enter; disp_val just holds.
      state     <= SEQ_LOAD_A;
      porta     <= '0;
      portb     <= '0;
      aluop     <= ALU_ADD;
      flags     <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        SEQ_LOAD_A: begin
          disp_val <= sw_val;
          if (enter_press) begin
            porta <= sw_val;
            state <= SEQ_LOAD_B;
          end
        end
        SEQ_LOAD_B: begin
          disp_val <= sw_val;
          if (enter_press) begin
            portb <= sw_val;
            state <= SEQ_LOAD_OP;
          end
        end
        SEQ_LOAD_OP: begin
          disp_val <= {28'b0, sw_sync[3:0]};
          if (enter_press) begin
            aluop <= aluop_t'(sw_sync[3:0]);
            state <= SEQ_SHOW;
          end
        end
        SEQ_SHOW: begin
          // res_valid is always low on SHOW entry, so it doubles as the
          // first-cycle marker for the one-time capture.
          if (enter_press) begin
            state     <= SEQ_LOAD_A;
            res_valid <= 1'b0;
          end else if (!res_valid) begin
            disp_val  <= alu.result;
            flags     <= {alu.negative, alu.overflow, alu.zero};
            res_valid <= 1'b1;
          end
        end
        default: state <= SEQ_LOAD_A;
      endcase
    end
  end

  assign alu.porta = porta;
  assign alu.portb = portb;
  assign alu.aluop = aluop;
  assign state_led = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;
  import cpu_types_pkg::*;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        rv;
    logic        cd;
    logic [31:0] dv;
    logic [2:0]  fl;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [17:0] SW  = '0;
  logic [3:0]  KEY = 4'hF;
  logic [31:0] disp_val;
  logic [2:0]  flags;
  logic        res_valid;
  logic [1:0]  state_led;

  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_q[$];

  alu_operand_sequencer_if bus ();

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW        (SW),
    .KEY       (KEY),
    .alu       (bus),
    .disp_val  (disp_val),
    .flags     (flags),
    .res_valid (res_valid),
    .state_led (state_led)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU on the registered operands.
  logic [31:0] alu_r;
  always_comb begin
    case (bus.aluop)
      ALU_ADD: alu_r = bus.porta + bus.portb;
      ALU_SUB: alu_r = bus.porta - bus.portb;
      ALU_AND: alu_r = bus.porta & bus.portb;
      ALU_OR:  alu_r = bus.porta | bus.portb;
      ALU_XOR: alu_r = bus.porta ^ bus.portb;
      default: alu_r = '0;
    endcase
  end
  assign bus.result   = alu_r;
  assign bus.negative = alu_r[31];
  assign bus.zero     = (alu_r == 32'd0);
  assign bus.overflow = (bus.aluop == ALU_ADD) ?
                          ((bus.porta[31] == bus.portb[31]) && (alu_r[31] != bus.porta[31])) :
                        (bus.aluop == ALU_SUB) ?
                          ((bus.porta[31] != bus.portb[31]) && (alu_r[31] != bus.porta[31])) : 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    end
  endfunction

  function automatic void push(input logic [1:0] st, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, input logic rv, input logic cd,
                               input logic [31:0] dv, input logic [2:0] fl);
    exp_t e;
    e.st = st; e.a = a; e.b = b; e.op = op; e.rv = rv; e.cd = cd; e.dv = dv; e.fl = fl;
    exp_q.push_back(e);
  endfunction

  // Monitor: every change of {state_led, res_valid} is a DUT event that must
  // match the next queued expectation.
  initial begin
    logic [2:0] prev_key;
    logic [2:0] cur_key;
    exp_t       e;
    prev_key = '0;
    forever begin
      @(negedge CLK);
      cur_key = {state_led, res_valid};
      if (!mon_en) begin
        prev_key = cur_key;
      end else if (cur_key != prev_key) begin
        prev_key = cur_key;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_event: got state=%0d res_valid=%0b, required no event",
                   state_led, res_valid);
        end else begin
          e = exp_q.pop_front();
          chk("ev_state", 32'(state_led), 32'(e.st));
          chk("ev_res_valid", 32'(res_valid), 32'(e.rv));
          chk("ev_porta", bus.porta, e.a);
          chk("ev_portb", bus.portb, e.b);
          chk("ev_aluop", 32'(bus.aluop), 32'(e.op));
          if (e.cd) begin
            chk("ev_disp_val", disp_val, e.dv);
            chk("ev_flags", 32'(flags), 32'(e.fl));
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_sw(input logic [17:0] v);
    tick(1);
    SW = v;
    tick(4);
  endtask

  task automatic press_keys(input logic [3:0] mask, input int hold);
    tick(1);
    KEY = KEY & ~mask;
    tick(hold);
    KEY = 4'hF;
    tick(15);
  endtask

  task automatic wait_drained(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(posedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: timeout with %0d expected events pending, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_porta"}, bus.porta, 32'h0);
    chk({tag, "_portb"}, bus.portb, 32'h0);
    chk({tag, "_aluop"}, 32'(bus.aluop), 32'h0);
    chk({tag, "_disp_val"}, disp_val, 32'h0);
    chk({tag, "_flags"}, 32'(flags), 32'h0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'h0);
    chk({tag, "_state_led"}, 32'(state_led), 32'h0);
  endtask

  initial begin
    // 1. Reset asserted mid-cycle takes effect without a clock edge.
    #13 RST = 1'b1;
    #1 check_all_zero("reset");
    tick(3);
    RST = 1'b0;
    tick(10);
    mon_en = 1'b1;

    // 2. Debounce: short glitch ignored, long press gives one advance.
    set_sw(18'h00005);
    tick(1);
    KEY[0] = 1'b0;
    tick(2);
    KEY[0] = 1'b1;
    tick(20);
    chk("glitch_state", 32'(state_led), 32'd0);
    push(2'd1, 32'h5, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5, 3'b000);
    press_keys(4'b0001, 20);
    wait_drained("press_a");

    // 3. Full sequence: 5 + (-3) = 2.
    set_sw(18'h1FFFD);
    push(2'd2, 32'h5, 32'hFFFFFFFD, 4'h0, 1'b0, 1'b1, 32'hFFFFFFFD, 3'b000);
    press_keys(4'b0001, 20);
    wait_drained("press_b");
    set_sw(18'h00000);
    push(2'd3, 32'h5, 32'hFFFFFFFD, 4'h0, 1'b0, 1'b1, 32'h0, 3'b000);
    push(2'd3, 32'h5, 32'hFFFFFFFD, 4'h0, 1'b1, 1'b1, 32'h2, 3'b000);
    press_keys(4'b0001, 20);
    wait_drained("show_add");

    // 6. Return from SHOW keeps operands, disp_val holds the result.
    set_sw(18'h00009);
    push(2'd0, 32'h5, 32'hFFFFFFFD, 4'h0, 1'b0, 1'b1, 32'h2, 3'b000);
    press_keys(4'b0001, 20);
    wait_drained("show_return");
    chk("track_settled", disp_val, 32'h9);
    SW = 18'h10000;
    tick(2);
    chk("track_lag2", disp_val, 32'h9);
    tick(1);
    chk("track_lag3", disp_val, 32'hFFFF0000);

    // SUB giving zero: 3 - 3.
    set_sw(18'h00003);
    push(2'd1, 32'h3, 32'hFFFFFFFD, 4'h0, 1'b0, 1'b1, 32'h3, 3'b000);
    press_keys(4'b0001, 20);
    push(2'd2, 32'h3, 32'h3, 4'h0, 1'b0, 1'b1, 32'h3, 3'b000);
    press_keys(4'b0001, 20);
    set_sw(18'h00001);
    push(2'd3, 32'h3, 32'h3, 4'h1, 1'b0, 1'b1, 32'h1, 3'b000);
    push(2'd3, 32'h3, 32'h3, 4'h1, 1'b1, 1'b1, 32'h0, 3'b001);
    press_keys(4'b0001, 20);
    wait_drained("show_sub_zero");

    // Clear from SHOW.
    push(2'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 3'b000);
    press_keys(4'b0010, 20);
    wait_drained("clear_show");
    chk("clear_flags", 32'(flags), 32'h0);

    // 4. Enter and clear together in LOAD_OP: clear wins.
    set_sw(18'h00005);
    push(2'd1, 32'h5, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5, 3'b000);
    press_keys(4'b0001, 20);
    set_sw(18'h00002);
    push(2'd2, 32'h5, 32'h2, 4'h0, 1'b0, 1'b1, 32'h2, 3'b000);
    press_keys(4'b0001, 20);
    set_sw(18'h00001);
    push(2'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 3'b000);
    press_keys(4'b0011, 20);
    wait_drained("clear_wins");

    // 5. Reset in LOAD_B, then re-enter operands: 0xA - 0xF = -5.
    set_sw(18'h00007);
    push(2'd1, 32'h7, 32'h0, 4'h0, 1'b0, 1'b1, 32'h7, 3'b000);
    press_keys(4'b0001, 20);
    wait_drained("load_b_7");
    push(2'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 3'b000);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1 check_all_zero("mid_reset");
    tick(2);
    RST = 1'b0;
    tick(10);
    wait_drained("mid_reset_ev");
    set_sw(18'h0000A);
    push(2'd1, 32'hA, 32'h0, 4'h0, 1'b0, 1'b1, 32'hA, 3'b000);
    press_keys(4'b0001, 20);
    set_sw(18'h0000F);
    push(2'd2, 32'hA, 32'hF, 4'h0, 1'b0, 1'b1, 32'hF, 3'b000);
    press_keys(4'b0001, 20);
    set_sw(18'h00001);
    push(2'd3, 32'hA, 32'hF, 4'h1, 1'b0, 1'b1, 32'h1, 3'b000);
    push(2'd3, 32'hA, 32'hF, 4'h1, 1'b1, 1'b1, 32'hFFFFFFFB, 3'b100);
    press_keys(4'b0001, 20);
    wait_drained("show_sub_neg");
    push(2'd0, 32'hA, 32'hF, 4'h1, 1'b0, 1'b1, 32'hFFFFFFFB, 3'b100);
    press_keys(4'b0001, 20);
    wait_drained("final_return");

    tick(10);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
